pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 30 +++
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/adder_stage.sv | 50 +++++
 rtl/pipelined_adder.sv | 84 ++++++++
 tb/tb_pipelined_adder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and the stage payload type for the pipelined adder.
package adder_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;

    // Payload fields are sized for the widest supported adder; narrower
    // instances simply leave the upper bits at zero.
    localparam int MAX_WIDTH  = 64;

    // One pipeline register worth of state. a/b travel in full so each stage
    // can pick its own slice; psum fills in from the bottom as stages finish.
    // b is already the effective operand (~b for subtract).
    typedef struct packed {
        logic                 valid;
        logic                 sub;
        logic                 carry;
        logic                 ovf;
        logic [MAX_WIDTH-1:0] psum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;

    // Legal geometry: evenly sliceable and fits the payload fields.
    function automatic bit cfg_ok(int width, int stages);
        return (stages > 0) && (width > 0) && (width <= MAX_WIDTH) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    // Producer/consumer side (testbench or upstream logic).
    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/adder_stage.sv
// One slice of the carry-pipelined adder: adds slice K of the operands plus
// the incoming carry and holds the result in its own pipeline register.
module adder_stage
    import adder_pkg::*;
#(
    parameter int SW    = 8,
    parameter int K     = 0,
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t d,
    input  logic   adv_next,
    output logic   adv,
    output stage_t q
);

    logic [SW:0] slice_sum;
    stage_t      nxt;

    // Slice add with carry chained from the previous stage's register.
    always_comb begin
        slice_sum = {1'b0, d.a[K*SW +: SW]} + {1'b0, d.b[K*SW +: SW]} +
                    {{SW{1'b0}}, d.carry};
    end

    // Next payload: pass everything through, fill in this slice and carry.
    // ovf is recomputed each stage; only the last stage sees the true MSB,
    // so its value is the one that reaches the output.
    always_comb begin
        nxt                   = d;
        nxt.psum[K*SW +: SW]  = slice_sum[SW-1:0];
        nxt.carry             = slice_sum[SW];
        nxt.ovf               = (d.a[WIDTH-1] == d.b[WIDTH-1]) &&
                                (slice_sum[SW-1] != d.a[WIDTH-1]);
    end

    // Move on when empty or when the downstream slot is freeing up.
    assign adv = !q.valid || adv_next;

    // Pipeline register; reset clears valid and the result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (adv) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor with valid/ready flow control.
// WIDTH is split into STAGES slices; each stage resolves one slice.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);

    localparam int SW = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and <= MAX_WIDTH");
    end

    stage_t              in_pl;
    stage_t              din [STAGES];
    stage_t              st  [STAGES];
    logic [STAGES-1:0]   valid;
    logic [STAGES-1:0]   adv_down;
    logic [STAGES-1:0]   adv;
    logic                acc;

    // Entry payload: fold subtract into ~b with a forced carry-in of 1.
    always_comb begin
        in_pl                = '0;
        in_pl.valid          = bus.in_valid;
        in_pl.sub            = bus.sub;
        in_pl.carry          = bus.sub ? 1'b1 : bus.ci;
        in_pl.a[WIDTH-1:0]   = bus.a;
        in_pl.b[WIDTH-1:0]   = bus.sub ? ~bus.b : bus.b;
    end

    // Downstream advance for each stage, built from registered valid bits
    // only: stage k+1 advances when out_ready is high or any stage from k+1
    // to the end holds a bubble. Same result as chaining each stage's adv,
    // without a combinational loop through one vector.
    always_comb begin
        acc = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv_down[k] = acc;
            acc         = acc || !valid[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign din[k] = in_pl;
        end else begin : g_rest
            assign din[k] = st[k-1];
        end

        assign valid[k] = st[k].valid;

        adder_stage #(
            .SW    (SW),
            .K     (k),
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .d        (din[k]),
            .adv_next (adv_down[k]),
            .adv      (adv[k]),
            .q        (st[k])
        );
    end

    // Outputs straight from the last register so they hold during a stall.
    assign bus.in_ready  = adv[0];
    assign bus.out_valid = st[STAGES-1].valid;
    assign bus.sum       = st[STAGES-1].psum[WIDTH-1:0];
    assign bus.co        = st[STAGES-1].carry;
    assign bus.ovf       = st[STAGES-1].ovf;

    // Operand copies and per-stage adv outputs past stage 0 have no reader.
    logic unused_ok;
    assign unused_ok = ^{st[STAGES-1], adv};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    res_t q_exp[$];
    bit   prev_stall = 0;
    res_t prev_out;
    int   pops = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' values.
    function automatic res_t model(logic [31:0] a, logic [31:0] b, logic ci, logic sub);
        res_t   r;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint us;
        longint ss;
        if (sub) begin
            us   = ua - ub;
            ss   = sa - sb;
            r.co = (ua >= ub);
        end else begin
            us   = ua + ub + longint'(ci);
            ss   = sa + sb + longint'(ci);
            r.co = (us >= 64'sh1_0000_0000);
        end
        r.sum = us[31:0];
        r.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // One clock cycle of handshake traffic with scoreboard bookkeeping.
    // Called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input bit iv, input bit ordy, input logic [31:0] ta,
                       input logic [31:0] tb_, input bit tci, input bit tsub,
                       output bit fin);
        res_t e;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.a         = ta;
        bus.b         = tb_;
        bus.ci        = tci;
        bus.sub       = tsub;
        #1;
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", {bus.sum, bus.co, bus.ovf},
                  {prev_out.sum, prev_out.co, prev_out.ovf});
        end
        fin = iv && bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (q_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%h exp=none", bus.sum);
            end else begin
                e = q_exp.pop_front();
                check("result", {bus.sum, bus.co, bus.ovf}, {e.sum, e.co, e.ovf});
                pops++;
            end
        end
        prev_stall   = bus.out_valid && !ordy;
        prev_out.sum = bus.sum;
        prev_out.co  = bus.co;
        prev_out.ovf = bus.ovf;
        if (fin) q_exp.push_back(model(ta, tb_, tci, tsub));
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[9];
    logic [31:0] opa[8];
    logic [31:0] opb[8];
    bit          opc[8];
    bit          ops[8];

    initial begin
        bit fin;
        int idx;
        int lat;
        int accepted;
        int cycles;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

        // Reset state, with a beat offered that must be ignored.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h1234_5678;
        bus.ci        = 1'b1;
        bus.sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_co", bus.co, 0);
        check("rst_ovf", bus.ovf, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        // Directed vectors: single beat, exact latency and values.
        foreach (vecs[i]) begin
            bus.a         = vecs[i].a;
            bus.b         = vecs[i].b;
            bus.ci        = vecs[i].ci;
            bus.sub       = vecs[i].sub;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            check("vec_in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 12) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("vec_latency", lat, S);
            check("vec_sum", bus.sum, vecs[i].sum);
            check("vec_co_ovf", {bus.co, bus.ovf}, {vecs[i].co, vecs[i].ovf});
            @(posedge clk);
            #1;
            check("vec_drained", bus.out_valid, 0);
        end

        // Back-to-back stream with backpressure from cycle 2, released at 10.
        for (int i = 0; i < 8; i++) begin
            opa[i] = rand_op();
            opb[i] = rand_op();
            opc[i] = 1'($urandom_range(0, 1));
            ops[i] = 1'($urandom_range(0, 1));
        end
        prev_stall = 0;
        pops = 0;
        idx = 0;
        for (int c = 0; c < 40 && pops < 8; c++) begin
            if (c == 9) begin
                check("stall_accepted", idx, 4);
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_out_valid", bus.out_valid, 1);
            end
            cyc(idx < 8, (c < 2) || (c >= 10), opa[idx % 8], opb[idx % 8],
                opc[idx % 8], ops[idx % 8], fin);
            if (fin) idx++;
        end
        check("stall_all_out", pops, 8);
        check("stall_q_empty", q_exp.size(), 0);

        // Alternating valid with out_ready low: bubbles must collapse.
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            cyc(c % 2 == 0, 1'b0, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), fin);
            if (fin) idx++;
        end
        check("bubble_accepted", idx, 4);
        check("bubble_in_ready", bus.in_ready, 0);
        for (int c = 0; c < 20 && q_exp.size() != 0; c++)
            cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, fin);
        check("bubble_q_empty", q_exp.size(), 0);

        // Reset with beats in flight: everything discarded at once.
        for (int c = 0; c < 4; c++)
            cyc(1'b1, 1'b0, rand_op(), rand_op(), 1'b0, 1'b0, fin);
        check("pre_rst_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.sum, 0);
        q_exp.delete();
        prev_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("post_rst_out_valid", bus.out_valid, 0);
            cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, fin);
        end

        // Random traffic against the reference model.
        accepted = 0;
        cycles = 0;
        while (accepted < 10000 && cycles < 60000) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rand_op(), rand_op(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fin);
            if (fin) accepted++;
            cycles++;
        end
        check("random_accepted", accepted, 10000);
        for (int c = 0; c < 50 && q_exp.size() != 0; c++)
            cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, fin);
        check("random_q_empty", q_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
